// File: rtl/usb_crc_serial.sv
// Bit-serial CRC engine for the USB device core: accumulates wire-order bits,
// flags a correct residue, and serialises the complemented CRC MSB-first.
module usb_crc_serial #(
  parameter int unsigned      WIDTH   = 5,
  parameter logic [WIDTH-1:0] POLY    = 5'b00101,
  parameter logic [WIDTH-1:0] INIT    = 5'b11111,
  parameter logic [WIDTH-1:0] RESIDUE = 5'b01100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             bit_valid,
  input  logic             bit_in,
  input  logic             append,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             bit_out,
  output logic             done,
  output logic [WIDTH-1:0] crc_out,
  output logic             crc_ok
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    APPEND = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] lfsr_step;
  logic             last_accept;

  // State register (together with the datapath flops it steers)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= INIT;
      shreg_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      shreg_q <= shreg_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign lfsr_step   = {lfsr_q[WIDTH-2:0], 1'b0} ^
                       ((lfsr_q[WIDTH-1] ^ bit_in) ? POLY : '0);
  assign last_accept = (state_q == APPEND) && out_ready && (count_q == CW'(1));

  // Next-state logic; start overrides everything else in every state
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (append) state_d = APPEND;
        APPEND:  if (last_accept) state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  // Datapath next values
  always_comb begin
    lfsr_d  = lfsr_q;
    shreg_d = shreg_q;
    count_d = count_q;
    done_d  = 1'b0;
    if (start) begin
      lfsr_d = INIT;
    end else begin
      case (state_q)
        RUN: begin
          if (bit_valid) lfsr_d = lfsr_step;
          // A bit arriving with append is folded in before the snapshot
          if (append) begin
            shreg_d = ~lfsr_d;
            count_d = CW'(WIDTH);
          end
        end
        APPEND: begin
          if (out_ready) begin
            shreg_d = shreg_q << 1;
            count_d = count_q - CW'(1);
            done_d  = last_accept;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    out_valid = (state_q == APPEND);
    bit_out   = (state_q == APPEND) & shreg_q[WIDTH-1];
    done      = done_q;
    crc_out   = lfsr_q;
    crc_ok    = (lfsr_q == RESIDUE);
  end

endmodule
